// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter between MEM-stage CPU port and debug port
// Define DMEM_ARB_STATS_EN to enable the saturating stall/grant counters.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = 64,
  parameter int ADDR_WIDTH   = $clog2(MEM_SIZE),
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cpu_mem_read,
  input  logic                  i_cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  input  logic [1:0]            i_cpu_mask,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_stall,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_ack,
  output logic                  o_dbg_err,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mask_1,
  output logic                  o_mask_2,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [15:0]           o_stall_cycles,
  output logic [15:0]           o_dbg_grants
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = ADDR_WIDTH'(MEM_SIZE - 4);
  localparam logic [3:0]            MAX_WAIT       = 4'(DBG_MAX_WAIT);

  typedef enum logic {ST_CPU, ST_DBG_RESP} state_e;

  state_e                  state_q;
  logic [3:0]              wait_cnt_q;
  logic                    ack_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic cpu_active;
  logic dbg_in_range;
  logic grant;
  logic dbg_sel;

  always_comb begin
    cpu_active   = i_cpu_mem_read | i_cpu_mem_write;
    dbg_in_range = (i_dbg_addr <= LAST_WORD_ADDR);
    grant        = !rst && (state_q == ST_CPU) && i_dbg_req &&
                   (!cpu_active || (wait_cnt_q == MAX_WAIT));
    // An out-of-range grant never takes the memory, so the CPU keeps it that cycle.
    dbg_sel      = grant && dbg_in_range;
  end

  always_comb begin
    if (dbg_sel) begin
      o_mem_read  = !i_dbg_we;
      o_mem_write = i_dbg_we;
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_wdata;
      o_mask_1    = 1'b0;
      o_mask_2    = 1'b0;
    end else begin
      o_mem_read  = i_cpu_mem_read & ~i_cpu_mem_write & ~rst;
      o_mem_write = i_cpu_mem_write & ~rst;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      o_mask_1    = i_cpu_mask[1];
      o_mask_2    = i_cpu_mask[0];
    end
  end

  assign o_cpu_rdata = i_mem_rdata;
  assign o_stall     = dbg_sel & cpu_active;
  assign o_dbg_ack   = ack_q & ~rst;
  assign o_dbg_err   = err_q & ~rst;
  assign o_dbg_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CPU;
      wait_cnt_q <= 4'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q == ST_CPU) begin
        if (grant) begin
          state_q    <= ST_DBG_RESP;
          wait_cnt_q <= 4'd0;
          ack_q      <= 1'b1;
          err_q      <= !dbg_in_range;
          if (dbg_in_range && !i_dbg_we) begin
            rdata_q <= i_mem_rdata;
          end
        end else if (!i_dbg_req) begin
          wait_cnt_q <= 4'd0;
        end else if (cpu_active && (wait_cnt_q != MAX_WAIT)) begin
          wait_cnt_q <= wait_cnt_q + 4'd1;
        end
      end else begin
        state_q <= ST_CPU;
        if (!i_dbg_req) begin
          wait_cnt_q <= 4'd0;
        end
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] dbg_grants_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 16'd0;
      dbg_grants_q   <= 16'd0;
    end else begin
      if (o_stall && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
      if (grant && (dbg_grants_q != 16'hFFFF)) begin
        dbg_grants_q <= dbg_grants_q + 16'd1;
      end
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_dbg_grants   = dbg_grants_q;
`else
  assign o_stall_cycles = 16'd0;
  assign o_dbg_grants   = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int DW   = 32;
  localparam int MS   = 64;
  localparam int AW   = 6;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cpu_mem_read, i_cpu_mem_write;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic [1:0]    i_cpu_mask;
  logic [DW-1:0] o_cpu_rdata;
  logic          o_stall;
  logic          i_dbg_req, i_dbg_we;
  logic [AW-1:0] i_dbg_addr;
  logic [DW-1:0] i_dbg_wdata;
  logic          o_dbg_ack, o_dbg_err;
  logic [DW-1:0] o_dbg_rdata;
  logic          o_mem_read, o_mem_write;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mask_1, o_mask_2;
  logic [DW-1:0] i_mem_rdata;
  logic [15:0]   o_stall_cycles, o_dbg_grants;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW), .DBG_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_mem_read(i_cpu_mem_read), .i_cpu_mem_write(i_cpu_mem_write),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata), .i_cpu_mask(i_cpu_mask),
    .o_cpu_rdata(o_cpu_rdata), .o_stall(o_stall),
    .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata), .o_dbg_ack(o_dbg_ack), .o_dbg_err(o_dbg_err),
    .o_dbg_rdata(o_dbg_rdata), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mask_1(o_mask_1),
    .o_mask_2(o_mask_2), .i_mem_rdata(i_mem_rdata),
    .o_stall_cycles(o_stall_cycles), .o_dbg_grants(o_dbg_grants)
  );

  // Word-granular memory stub driven by the DUT's memory port.
  logic [DW-1:0] stub_mem [16];
  assign i_mem_rdata = stub_mem[o_mem_addr[5:2]];
  always @(posedge clk) if (o_mem_write === 1'b1) stub_mem[o_mem_addr[5:2]] <= o_mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: the request's waited count, whether the previous cycle granted,
  // the ack/err/rdata the DUT must present this cycle, a mirror memory and counters.
  bit            started = 1'b0;
  bit            m_resp;
  int            m_waited;
  bit            m_ack, m_err;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [16];
  int            m_stalls, m_grants;

  bit            busy, inr, can_grant, dsel;
  logic          e_rd, e_wr, e_m1, e_m2;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    #2;
    if (started) begin
      busy      = i_cpu_mem_read | i_cpu_mem_write;
      inr       = (int'(i_dbg_addr) <= MS - 4);
      can_grant = !rst && !m_resp && i_dbg_req && (!busy || m_waited >= MAXW);
      dsel      = can_grant && inr;
      if (dsel) begin
        e_rd = !i_dbg_we; e_wr = i_dbg_we; e_addr = i_dbg_addr; e_wdata = i_dbg_wdata;
        e_m1 = 1'b0; e_m2 = 1'b0;
      end else begin
        e_wr = i_cpu_mem_write && !rst;
        e_rd = i_cpu_mem_read && !i_cpu_mem_write && !rst;
        e_addr = i_cpu_addr; e_wdata = i_cpu_wdata;
        e_m1 = i_cpu_mask[1]; e_m2 = i_cpu_mask[0];
      end
      chk("mem_read", o_mem_read, e_rd);
      chk("mem_write", o_mem_write, e_wr);
      chk("mem_addr", o_mem_addr, e_addr);
      chk("mem_wdata", o_mem_wdata, e_wdata);
      chk("mask", {o_mask_1, o_mask_2}, {e_m1, e_m2});
      chk("stall", o_stall, dsel && busy);
      chk("dbg_ack", o_dbg_ack, m_ack && !rst);
      chk("dbg_err", o_dbg_err, m_err && !rst);
      chk("dbg_rdata", o_dbg_rdata, m_rdata);
      chk("cpu_rdata", o_cpu_rdata, i_mem_rdata);
`ifdef DMEM_ARB_STATS_EN
      chk("stall_cycles", o_stall_cycles, m_stalls);
      chk("dbg_grants", o_dbg_grants, m_grants);
`else
      chk("stall_cycles_off", o_stall_cycles, 0);
      chk("dbg_grants_off", o_dbg_grants, 0);
`endif
      if (rst) begin
        m_resp = 0; m_waited = 0; m_ack = 0; m_err = 0; m_rdata = '0;
        m_stalls = 0; m_grants = 0;
      end else begin
        if (dsel && busy && m_stalls < 65535) m_stalls++;
        if (can_grant && m_grants < 65535) m_grants++;
        if (can_grant) begin
          if (dsel && !i_dbg_we) m_rdata = m_mem[i_dbg_addr[5:2]];
          m_resp = 1; m_waited = 0; m_ack = 1; m_err = !inr;
        end else begin
          if (!i_dbg_req) m_waited = 0;
          else if (!m_resp && busy && m_waited < MAXW) m_waited++;
          m_resp = 0; m_ack = 0; m_err = 0;
        end
      end
      if (e_wr) m_mem[e_addr[5:2]] = e_wdata;
    end
  end

  task automatic cpu_idle();
    i_cpu_mem_read = 1'b0; i_cpu_mem_write = 1'b0;
  endtask

  // CPU loads every cycle while a debug read waits; forced grant lands on the fifth cycle.
  task automatic scen2();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      rst = 1'b0;
      i_cpu_mem_read = (k < 6); i_cpu_mem_write = 1'b0; i_cpu_addr = 6'd12; i_cpu_mask = 2'b00;
      i_dbg_req = (k < 5); i_dbg_we = 1'b0; i_dbg_addr = 6'd8;
      #3;
      if (k < 4) begin
        chk("s2_wait_stall", o_stall, 1'b0);
        chk("s2_wait_addr", o_mem_addr, 6'd12);
      end else if (k == 4) begin
        chk("s2_force_stall", o_stall, 1'b1);
        chk("s2_force_addr", o_mem_addr, 6'd8);
      end else if (k == 5) begin
        chk("s2_ack", o_dbg_ack, 1'b1);
        chk("s2_reserve_stall", o_stall, 1'b0);
        chk("s2_reserve_read", o_mem_read, 1'b1);
        chk("s2_rdata", o_dbg_rdata, 32'hDEADBEEF);
      end
    end
  endtask

  bit stall_seen;
  bit pend;

  initial begin
    for (int i = 0; i < 16; i++) begin stub_mem[i] = '0; m_mem[i] = '0; end
    m_resp = 0; m_waited = 0; m_ack = 0; m_err = 0; m_rdata = '0; m_stalls = 0; m_grants = 0;
    rst = 1'b1; cpu_idle(); i_cpu_addr = '0; i_cpu_wdata = '0; i_cpu_mask = 2'b00;
    i_dbg_req = 1'b0; i_dbg_we = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    started = 1'b1;
    i_cpu_mem_read = 1'b1; i_cpu_addr = 6'd5;
    #3;
    chk("rst_mem_read", o_mem_read, 1'b0);
    chk("rst_mem_addr", o_mem_addr, 6'd5);
    chk("rst_ack", o_dbg_ack, 1'b0);
    chk("rst_rdata", o_dbg_rdata, 32'd0);

    // Idle CPU: debug write then read-back of address 8.
    @(negedge clk);
    rst = 1'b0; cpu_idle();
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 6'd8; i_dbg_wdata = 32'hDEADBEEF;
    #3;
    chk("s1_wr", o_mem_write, 1'b1);
    chk("s1_addr", o_mem_addr, 6'd8);
    chk("s1_mask", {o_mask_1, o_mask_2}, 2'b00);
    chk("s1_stall", o_stall, 1'b0);
    @(negedge clk); i_dbg_req = 1'b0; #3;
    chk("s1_ack", o_dbg_ack, 1'b1);
    chk("s1_err", o_dbg_err, 1'b0);
    @(negedge clk); i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 6'd8; #3;
    chk("s1_rd", o_mem_read, 1'b1);
    @(negedge clk); i_dbg_req = 1'b0; #3;
    chk("s1_rd_ack", o_dbg_ack, 1'b1);
    chk("s1_rd_data", o_dbg_rdata, 32'hDEADBEEF);

    scen2();

    // Highest in-range address, then first out-of-range address.
    @(negedge clk); cpu_idle(); i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 6'd60; #3;
    chk("s3_edge_rd", o_mem_read, 1'b1);
    @(negedge clk); i_dbg_req = 1'b0; #3;
    chk("s3_edge_err", o_dbg_err, 1'b0);
    @(negedge clk); i_dbg_req = 1'b1; i_dbg_addr = 6'd61; #3;
    chk("s3_oor_rd", o_mem_read, 1'b0);
    chk("s3_oor_stall", o_stall, 1'b0);
    @(negedge clk); i_dbg_req = 1'b0; #3;
    chk("s3_oor_ack", o_dbg_ack, 1'b1);
    chk("s3_oor_err", o_dbg_err, 1'b1);
    chk("s3_oor_rdata", o_dbg_rdata, 32'h0);

    // CPU byte store, then read+write together.
    @(negedge clk);
    i_cpu_mem_write = 1'b1; i_cpu_addr = 6'd3; i_cpu_wdata = 32'h5A; i_cpu_mask = 2'b11; #3;
    chk("s4_mask", {o_mask_1, o_mask_2}, 2'b11);
    chk("s4_wr", o_mem_write, 1'b1);
    chk("s4_addr", o_mem_addr, 6'd3);
    @(negedge clk); i_cpu_mem_read = 1'b1; #3;
    chk("s4_rw_read", o_mem_read, 1'b0);

    // Reset during the response cycle.
    @(negedge clk); cpu_idle(); i_cpu_mask = 2'b00;
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 6'd16; i_dbg_wdata = 32'h1234; #3;
    chk("s5_grant", o_mem_write, 1'b1);
    @(negedge clk); rst = 1'b1; #3;
    chk("s5_ack_suppressed", o_dbg_ack, 1'b0);
    @(negedge clk); rst = 1'b0; #3;
    chk("s5_regrant", o_mem_write, 1'b1);
    chk("s5_regrant_addr", o_mem_addr, 6'd16);
    @(negedge clk); i_dbg_req = 1'b0; #3;
    chk("s5_ack", o_dbg_ack, 1'b1);

    // Statistics after two forced-grant scenarios.
    @(negedge clk); rst = 1'b1; #3;
    scen2();
    scen2();
    @(negedge clk); cpu_idle(); i_dbg_req = 1'b0; #3;
`ifdef DMEM_ARB_STATS_EN
    chk("s6_stall_cycles", o_stall_cycles, 16'd2);
    chk("s6_dbg_grants", o_dbg_grants, 16'd2);
`else
    chk("s6_stall_cycles", o_stall_cycles, 16'd0);
    chk("s6_dbg_grants", o_dbg_grants, 16'd0);
`endif

    // Randomized traffic; a stalled CPU request is held until served.
    stall_seen = 1'b0;
    pend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (!stall_seen) begin
        case ($urandom_range(0, 3))
          0: begin i_cpu_mem_read = 1'b0; i_cpu_mem_write = 1'b0; end
          1: begin i_cpu_mem_read = 1'b1; i_cpu_mem_write = 1'b0; end
          2: begin i_cpu_mem_read = 1'b0; i_cpu_mem_write = 1'b1; end
          default: begin i_cpu_mem_read = 1'b1; i_cpu_mem_write = 1'b1; end
        endcase
        i_cpu_addr  = AW'($urandom_range(0, 63));
        i_cpu_wdata = $urandom;
        i_cpu_mask  = 2'($urandom_range(0, 3));
      end
      if (o_dbg_ack) begin
        pend = 1'b0; i_dbg_req = 1'b0;
      end else if (pend && $urandom_range(0, 49) == 0) begin
        pend = 1'b0; i_dbg_req = 1'b0;
      end else if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1; i_dbg_req = 1'b1;
        i_dbg_we    = 1'($urandom_range(0, 1));
        i_dbg_addr  = AW'($urandom_range(0, 63));
        i_dbg_wdata = $urandom;
      end
      #3;
      stall_seen = o_stall;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
